// File: rtl/mm_sequencer.sv
// mm_sequencer: operand staging and control for the 3x3 MAC array.
// Collects A then B (18 x 4-bit elements), runs a clear cycle and three
// accumulate cycles on the array, then streams the nine results out.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LOAD   | accept 18 elements into the operand buffer
// ST_CLEAR  | one cycle, clear every array accumulator
// ST_MAC    | three cycles, broadcast column k of A and row k of B
// ST_UNLOAD | present res_in downstream, advance array index per transfer
// ST_DONE   | one-cycle done pulse, then back to ST_LOAD

module mm_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [3:0] data_w1,
    output logic [3:0] data_w2,
    output logic [3:0] data_w3,
    output logic [3:0] data_x1,
    output logic [3:0] data_x2,
    output logic [3:0] data_x3,
    output logic [8:0] load,
    output logic [8:0] clear,
    output logic       unload_res,
    input  logic [9:0] res_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_data,
    output logic [3:0] out_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CLEAR,
        ST_MAC,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    state_t     state;
    logic [4:0] elem_cnt;
    logic [1:0] k;
    logic [3:0] res_idx;
    logic [3:0] elem_buf [18];

    // Column k of A sits at k, 3+k, 6+k; row k of B at 9+3k, 10+3k, 11+3k.
    logic [4:0] col_a;
    logic [4:0] row_b;
    assign col_a = {3'b000, k};
    assign row_b = 5'd9 + ({3'b000, k} * 5'd3);

    // Sequencing FSM: state, element counter, MAC step and result index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_LOAD;
            elem_cnt <= '0;
            k        <= '0;
            res_idx  <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (elem_cnt == 5'd17) begin
                            elem_cnt <= '0;
                            state    <= ST_CLEAR;
                        end else begin
                            elem_cnt <= elem_cnt + 5'd1;
                        end
                    end
                end
                ST_CLEAR: begin
                    k     <= '0;
                    state <= ST_MAC;
                end
                ST_MAC: begin
                    if (k == 2'd2) begin
                        k       <= '0;
                        res_idx <= '0;
                        state   <= ST_UNLOAD;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (res_idx == 4'd8) begin
                            res_idx <= '0;
                            state   <= ST_DONE;
                        end else begin
                            res_idx <= res_idx + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_LOAD;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // Operand buffer; contents after reset are irrelevant, so no reset term.
    always_ff @(posedge clk) begin
        if (rst_n && (state == ST_LOAD) && in_valid) begin
            elem_buf[elem_cnt] <= in_data;
        end
    end

    // Output decode from the state register, forced to zero while in reset
    // so nothing reaches the array or the consumer during a reset cycle.
    always_comb begin
        in_ready   = 1'b0;
        data_w1    = '0;
        data_w2    = '0;
        data_w3    = '0;
        data_x1    = '0;
        data_x2    = '0;
        data_x3    = '0;
        load       = '0;
        clear      = '0;
        unload_res = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_idx    = '0;
        busy       = 1'b0;
        done       = 1'b0;
        if (rst_n) begin
            busy = (state != ST_LOAD);
            case (state)
                ST_LOAD: begin
                    in_ready = 1'b1;
                end
                ST_CLEAR: begin
                    clear = 9'h1FF;
                end
                ST_MAC: begin
                    load    = 9'h1FF;
                    data_w1 = elem_buf[col_a];
                    data_w2 = elem_buf[col_a + 5'd3];
                    data_w3 = elem_buf[col_a + 5'd6];
                    data_x1 = elem_buf[row_b];
                    data_x2 = elem_buf[row_b + 5'd1];
                    data_x3 = elem_buf[row_b + 5'd2];
                end
                ST_UNLOAD: begin
                    out_valid  = 1'b1;
                    out_data   = res_in;
                    out_idx    = res_idx;
                    unload_res = out_ready;
                end
                ST_DONE: begin
                    done = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_sequencer.sv
// Bench for mm_sequencer: a behavioural 3x3 MAC array model drives res_in,
// a table of jobs is run through the sequencer and results are compared
// against expected matrix products.

module tb_mm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] data_w1, data_w2, data_w3;
    logic [3:0] data_x1, data_x2, data_x3;
    logic [8:0] load;
    logic [8:0] clear;
    logic       unload_res;
    logic [9:0] res_in;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;
    logic [3:0] out_idx;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    mm_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .data_w1    (data_w1),
        .data_w2    (data_w2),
        .data_w3    (data_w3),
        .data_x1    (data_x1),
        .data_x2    (data_x2),
        .data_x3    (data_x3),
        .load       (load),
        .clear      (clear),
        .unload_res (unload_res),
        .res_in     (res_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done)
    );

    // Array model: cell n = (n/3, n%3) accumulates w[row]*x[col].
    logic [3:0] wv [3];
    logic [3:0] xv [3];
    logic [9:0] acc [9];
    logic [3:0] arr_idx;
    assign wv[0] = data_w1;
    assign wv[1] = data_w2;
    assign wv[2] = data_w3;
    assign xv[0] = data_x1;
    assign xv[1] = data_x2;
    assign xv[2] = data_x3;
    assign res_in = acc[arr_idx];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < 9; n++) acc[n] <= '0;
            arr_idx <= '0;
        end else begin
            for (int n = 0; n < 9; n++) begin
                if (clear[n]) acc[n] <= '0;
                else if (load[n]) acc[n] <= acc[n] + 10'(wv[n/3]) * 10'(xv[n%3]);
            end
            if (unload_res) arr_idx <= (arr_idx == 4'd8) ? 4'd0 : arr_idx + 4'd1;
        end
    end

    typedef struct {
        logic [8:0][3:0] a;
        logic [8:0][3:0] b;
        logic [8:0][9:0] c;
        bit              gap;
        int              rmode;  // 0 always ready, 1 pattern 1,0,0, 2 random
        bit              timed;
    } vec_t;

    vec_t vecs [8];
    int   c_desc [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    int n_compared = 0;
    int n_mismatch = 0;
    int n_load = 0, n_clear = 0, n_unload = 0, n_done = 0;

    task automatic check(input string name, input int act, input int exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0][9:0] matmul(input logic [8:0][3:0] a, input logic [8:0][3:0] b);
        logic [8:0][9:0] c;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s = 0;
                for (int kk = 0; kk < 3; kk++) s += int'(a[i*3+kk]) * int'(b[kk*3+j]);
                c[i*3+j] = 10'(s);
            end
        return c;
    endfunction

    // Per-cycle protocol checks, called once per cycle after inputs settle.
    task automatic cyc_sample();
        if (rst_n) begin
            if (load != 9'h0) begin
                n_load++;
                check("load_mask", int'(load), 'h1FF);
            end
            if (clear != 9'h0) begin
                n_clear++;
                check("clear_mask", int'(clear), 'h1FF);
                check("clear_load_excl", int'(load), 0);
            end
            if (load == 9'h0)
                check("bus_idle_zero", int'({data_w1, data_w2, data_w3, data_x1, data_x2, data_x3}), 0);
            check("unload_handshake", int'(unload_res), int'(out_valid & out_ready));
            check("busy_not_ready", int'(busy), int'(!in_ready));
            if (out_valid) check("out_passthru", int'(out_data), int'(res_in));
            if (unload_res) n_unload++;
            if (done) n_done++;
        end
    endtask

    task automatic load_elems(input logic [8:0][3:0] a, input logic [8:0][3:0] b, input bit gap);
        int idx = 0;
        int guard = 0;
        bit acc_now;
        logic [3:0] el [18];
        for (int i = 0; i < 9; i++) begin
            el[i]     = a[i];
            el[i + 9] = b[i];
        end
        while (idx < 18 && guard < 400) begin
            in_valid  = gap ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data   = el[idx];
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            cyc_sample();
            acc_now = in_valid && in_ready;
            @(negedge clk);
            if (acc_now) idx++;
            guard++;
        end
        if (idx < 18) check("load_timeout", idx, 18);
    endtask

    task automatic run_job(input vec_t v);
        int l0 = n_load, c0 = n_clear, u0 = n_unload, d0 = n_done;
        int cyc = 0, n = 0, p = 0;
        bit got_done = 0, hold = 0;
        logic [9:0] hd;
        logic [3:0] hi;
        load_elems(v.a, v.b, v.gap);
        while (!got_done && cyc < 300) begin
            cyc++;
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            case (v.rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (p % 3 == 0);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            #1;
            cyc_sample();
            if (v.timed && cyc == 1) check("clear_cycle1", int'(clear), 'h1FF);
            if (v.timed && cyc == 5) check("valid_cycle5", int'(out_valid), 1);
            if (hold) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), int'(hd));
                check("hold_idx", int'(out_idx), int'(hi));
            end
            hold = 0;
            if (out_valid) begin
                p++;
                if (out_ready) begin
                    if (n < 9) begin
                        check("result_data", int'(out_data), int'(v.c[n]));
                        check("result_idx", int'(out_idx), n);
                    end
                    n++;
                end else begin
                    hold = 1;
                    hd   = out_data;
                    hi   = out_idx;
                end
            end
            if (done) begin
                got_done = 1;
                check("results_before_done", n, 9);
                if (v.timed) check("done_cycle14", cyc, 14);
            end
            @(negedge clk);
        end
        if (!got_done) check("done_timeout", 0, 1);
        in_valid = 1'b0;
        #1;
        cyc_sample();
        check("ready_after_done", int'(in_ready), 1);
        check("load_cycles", n_load - l0, 3);
        check("clear_cycles", n_clear - c0, 1);
        check("unload_pulses", n_unload - u0, 9);
        check("done_pulses", n_done - d0, 1);
    endtask

    initial begin
        vec_t rv;
        int l0, c0, u0;
        for (int i = 0; i < 9; i++) begin
            vecs[0].a[i] = (i % 4 == 0) ? 4'd1 : 4'd0;
            vecs[0].b[i] = 4'(i + 1);
            vecs[0].c[i] = 10'(i + 1);
            vecs[1].a[i] = 4'd15;
            vecs[1].b[i] = 4'd15;
            vecs[1].c[i] = 10'd675;
            vecs[2].a[i] = 4'(i + 1);
            vecs[2].b[i] = 4'(9 - i);
            vecs[2].c[i] = 10'(c_desc[i]);
            vecs[3].a[i] = 4'd2;
            vecs[3].b[i] = 4'd2;
            vecs[3].c[i] = 10'd12;
            vecs[4].a[i] = 4'd3;
            vecs[4].b[i] = 4'd3;
            vecs[4].c[i] = 10'd27;
        end
        for (int t = 0; t < 5; t++) begin
            vecs[t].gap   = 0;
            vecs[t].rmode = (t == 2) ? 1 : 0;
            vecs[t].timed = (t != 2);
        end
        for (int t = 5; t < 8; t++) begin
            for (int i = 0; i < 9; i++) begin
                vecs[t].a[i] = 4'($urandom);
                vecs[t].b[i] = 4'($urandom);
            end
            vecs[t].c     = matmul(vecs[t].a, vecs[t].b);
            vecs[t].gap   = 1;
            vecs[t].rmode = 2;
            vecs[t].timed = 0;
        end

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'd5;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs_zero", int'({in_ready, out_valid, unload_res, load, clear, busy, done,
              out_data, out_idx, data_w1, data_w2, data_w3, data_x1, data_x2, data_x3}), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("ready_after_reset", int'(in_ready), 1);
        check("busy_after_reset", int'(busy), 0);
        @(negedge clk);

        for (int t = 0; t < 8; t++) run_job(vecs[t]);

        // Reset during MAC k=1 abandons the job.
        for (int i = 0; i < 9; i++) begin
            rv.a[i] = 4'($urandom_range(1, 15));
            rv.b[i] = 4'($urandom_range(1, 15));
        end
        l0 = n_load;
        c0 = n_clear;
        u0 = n_unload;
        load_elems(rv.a, rv.b, 0);
        for (int cyc = 1; cyc <= 2; cyc++) begin
            in_valid = 1'b0;
            #1;
            cyc_sample();
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midjob_reset_zero", int'({in_ready, out_valid, unload_res, load, clear, busy, done,
              out_data, out_idx, data_w1, data_w2, data_w3, data_x1, data_x2, data_x3}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_midjob_reset", int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            cyc_sample();
            @(negedge clk);
            #1;
        end
        check("abort_load_cycles", n_load - l0, 1);
        check("abort_clear_cycles", n_clear - c0, 1);
        check("abort_unload_pulses", n_unload - u0, 0);

        for (int i = 0; i < 9; i++) begin
            rv.a[i] = 4'($urandom);
            rv.b[i] = 4'($urandom);
        end
        rv.c     = matmul(rv.a, rv.b);
        rv.gap   = 1;
        rv.rmode = 0;
        rv.timed = 0;
        run_job(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
